recip_issue_arbiter: RTL

RECIP_ISSUE_ARBITER -- requirements
Module: recip_issue_arbiter

---
 rtl/recip_issue_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/recip_issue_arbiter.sv
// recip_issue_arbiter: round-robin issue of NUM_REQ operand streams into one shared pipelined reciprocal unit.
// Latency: LATENCY enabled cycles from grant to result; the grant and accept path is combinational.
// Backpressure: a stalled result head (respValid && !respReady) freezes the unit (recipCe=0) and blocks new grants.
// Optional feature: define RECIP_ISSUE_ARBITER_FLUSH_EN to add a synchronous flush input.
module recip_issue_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FLOAT_SIZE = 32,
    parameter int LATENCY    = 25,
    parameter int ID_SIZE    = 2
) (
    input  logic                             clk,
    input  logic                             reset,
`ifdef RECIP_ISSUE_ARBITER_FLUSH_EN
    input  logic                             flush,
`endif
    input  logic [NUM_REQ-1:0]               reqValid,
    output logic [NUM_REQ-1:0]               reqReady,
    input  logic [NUM_REQ*FLOAT_SIZE-1:0]    reqData,
    output logic                             respValid,
    input  logic                             respReady,
    output logic [FLOAT_SIZE-1:0]            respData,
    output logic [ID_SIZE-1:0]               respId,
    output logic                             recipCe,
    output logic [FLOAT_SIZE-1:0]            recipIn,
    input  logic [FLOAT_SIZE-1:0]            recipOut,
    output logic [$clog2(LATENCY+1)-1:0]     inFlight
);

    localparam int CNT_W = $clog2(LATENCY+1);

    // Tracking slots: index 0 is the newest issue, index LATENCY-1 is aligned with recipOut.
    logic [LATENCY-1:0]    r_slotVld;
    logic [ID_SIZE-1:0]    r_slotId [LATENCY];
    logic [ID_SIZE-1:0]    r_rrPtr;
    logic [FLOAT_SIZE-1:0] r_recipIn;
    logic [CNT_W-1:0]      r_inFlight;

    logic                  w_headVld;
    logic                  w_advance;
    logic                  w_anyReq;
    logic                  w_grant;
    logic                  w_respHs;
    logic                  w_flush;
    logic [ID_SIZE-1:0]    w_grantId;

`ifdef RECIP_ISSUE_ARBITER_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // The whole pipe moves together; it only stops when a valid result is waiting on the consumer.
    assign w_headVld = r_slotVld[LATENCY-1];
    assign w_advance = !w_headVld || respReady;
    assign w_respHs  = w_headVld && respReady;

    // Round-robin pick: scan offsets from the highest down so the smallest offset from rrPtr wins.
    always_comb begin
        w_anyReq  = 1'b0;
        w_grantId = '0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            if (reqValid[(int'(r_rrPtr) + k) % NUM_REQ]) begin
                w_anyReq  = 1'b1;
                w_grantId = ID_SIZE'((int'(r_rrPtr) + k) % NUM_REQ);
            end
        end
    end

    // Nothing is accepted while reset is held, so recipIn shows its cleared value.
    assign w_grant = w_anyReq && w_advance && !w_flush && !reset;

    // One-hot accept towards the winning requester only.
    always_comb begin
        reqReady = '0;
        if (w_grant) begin
            reqReady[w_grantId] = 1'b1;
        end
    end

    assign recipIn   = w_grant ? reqData[w_grantId*FLOAT_SIZE +: FLOAT_SIZE] : r_recipIn;
    assign recipCe   = w_advance;
    assign respValid = w_headVld;
    assign respData  = recipOut;
    assign respId    = r_slotId[LATENCY-1];
    assign inFlight  = r_inFlight;

    // Valid bits, round-robin pointer, operand hold register and occupancy counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slotVld  <= '0;
            r_rrPtr    <= '0;
            r_recipIn  <= '0;
            r_inFlight <= '0;
        end else begin
            if (w_flush) begin
                r_slotVld <= '0;
            end else if (w_advance) begin
                r_slotVld <= {r_slotVld[LATENCY-2:0], w_grant};
            end
            if (w_grant) begin
                r_rrPtr   <= ID_SIZE'((int'(w_grantId) + 1) % NUM_REQ);
                r_recipIn <= recipIn;
            end
            if (w_flush) begin
                r_inFlight <= '0;
            end else if (w_grant && !w_respHs) begin
                r_inFlight <= r_inFlight + CNT_W'(1);
            end else if (!w_grant && w_respHs) begin
                r_inFlight <= r_inFlight - CNT_W'(1);
            end
        end
    end

    // Requester IDs ride alongside the valid bits; their content is ignored when the matching valid is 0.
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_slotId[0] <= w_grantId;
            for (int i = 1; i < LATENCY; i++) begin
                r_slotId[i] <= r_slotId[i-1];
            end
        end
    end

endmodule
